// File: rtl/mdu_hilo_ctrl_pkg.sv
// Shared control codes, FSM encoding and op-class helpers for the MDU HI/LO sequencer.
package mdu_hilo_ctrl_pkg;

  localparam logic [4:0] NOP_CONTROL   = 5'd0;
  localparam logic [4:0] MULT_CONTROL  = 5'd1;
  localparam logic [4:0] MULTU_CONTROL = 5'd2;
  localparam logic [4:0] DIV_CONTROL   = 5'd3;
  localparam logic [4:0] DIVU_CONTROL  = 5'd4;
  localparam logic [4:0] MTHI_CONTROL  = 5'd5;
  localparam logic [4:0] MTLO_CONTROL  = 5'd6;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  function automatic logic is_mul(input logic [4:0] ctrl);
    return (ctrl == MULT_CONTROL) || (ctrl == MULTU_CONTROL);
  endfunction

  function automatic logic is_div(input logic [4:0] ctrl);
    return (ctrl == DIV_CONTROL) || (ctrl == DIVU_CONTROL);
  endfunction

endpackage

// File: rtl/mdu_hilo_ctrl_if.sv
// EX-side operation request, MDU operand/result channel and HI/LO/stall outputs.
interface mdu_hilo_ctrl_if #(
  parameter int WIDTH = 32
);
  logic               op_valid;
  logic [4:0]         op_ctrl;
  logic [WIDTH-1:0]   op_a;
  logic [WIDTH-1:0]   op_b;
  logic               flush;
  logic [4:0]         mdu_ctrl;
  logic [WIDTH-1:0]   mdu_a;
  logic [WIDTH-1:0]   mdu_b;
  logic [2*WIDTH-1:0] mdu_result;
  logic               mdu_ready;
  logic               stall;
  logic [WIDTH-1:0]   hi;
  logic [WIDTH-1:0]   lo;
  logic               busy;

  modport slave (
    input  op_valid, op_ctrl, op_a, op_b, flush, mdu_result, mdu_ready,
    output mdu_ctrl, mdu_a, mdu_b, stall, hi, lo, busy
  );

  modport master (
    output op_valid, op_ctrl, op_a, op_b, flush, mdu_result, mdu_ready,
    input  mdu_ctrl, mdu_a, mdu_b, stall, hi, lo, busy
  );
endinterface

// File: rtl/mdu_hilo_ctrl_hilo_regfile.sv
// Architectural HI/LO pair: 2*WIDTH commit port plus single-word MTHI/MTLO writes.
module mdu_hilo_ctrl_hilo_regfile #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_commit,
  input  logic [2*WIDTH-1:0] i_result,
  input  logic               i_hi_we,
  input  logic               i_lo_we,
  input  logic [WIDTH-1:0]   i_wdata,
  output logic [WIDTH-1:0]   o_hi,
  output logic [WIDTH-1:0]   o_lo
);

  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (i_commit) begin
      r_hi <= i_result[2*WIDTH-1:WIDTH];
      r_lo <= i_result[WIDTH-1:0];
    end else begin
      if (i_hi_we) r_hi <= i_wdata;
      if (i_lo_we) r_lo <= i_wdata;
    end
  end

  assign o_hi = r_hi;
  assign o_lo = r_lo;

endmodule

// File: rtl/mdu_hilo_ctrl.sv
// EX-stage MDU sequencer: latches operands, stalls until the result is due, commits HI/LO.
// Multiply completes on a fixed countdown; divide waits for mdu_ready; flush aborts without commit.
module mdu_hilo_ctrl
  import mdu_hilo_ctrl_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MUL_LATENCY = 1
) (
  input  logic           clk,
  input  logic           rst,
  mdu_hilo_ctrl_if.slave bus
);

  localparam int CNT_W = (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MUL_LATENCY - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [4:0]       r_mdu_ctrl;
  logic [WIDTH-1:0] r_mdu_a;
  logic [WIDTH-1:0] r_mdu_b;
  logic             w_stall;
  logic             w_start;
  logic             w_done;
  logic             w_commit;
  logic             w_hi_we;
  logic             w_lo_we;

  always_comb begin
    w_state_nxt = r_state;
    w_stall     = 1'b0;
    w_start     = 1'b0;
    w_done      = 1'b0;
    w_commit    = 1'b0;
    w_hi_we     = 1'b0;
    w_lo_we     = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.op_valid && !bus.flush) begin
          if (is_mul(bus.op_ctrl) || is_div(bus.op_ctrl)) begin
            w_start     = 1'b1;
            w_stall     = 1'b1;
            w_state_nxt = BUSY;
          end else if (bus.op_ctrl == MTHI_CONTROL) begin
            w_hi_we = 1'b1;
          end else if (bus.op_ctrl == MTLO_CONTROL) begin
            w_lo_we = 1'b1;
          end
        end
      end
      BUSY: begin
        // Flush outranks a same-cycle result so an annulled op never lands in HI/LO.
        if (bus.flush) begin
          w_done      = 1'b1;
          w_state_nxt = IDLE;
        end else if (is_mul(r_mdu_ctrl)) begin
          if (r_cnt != '0) begin
            w_stall = 1'b1;
          end else begin
            w_commit    = 1'b1;
            w_done      = 1'b1;
            w_state_nxt = IDLE;
          end
        end else if (bus.mdu_ready) begin
          w_commit    = 1'b1;
          w_done      = 1'b1;
          w_state_nxt = IDLE;
        end else begin
          w_stall = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_mdu_ctrl <= NOP_CONTROL;
      r_mdu_a    <= '0;
      r_mdu_b    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_start) begin
        r_mdu_ctrl <= bus.op_ctrl;
        r_mdu_a    <= bus.op_a;
        r_mdu_b    <= bus.op_b;
        r_cnt      <= CNT_INIT;
      end else begin
        if (w_done) r_mdu_ctrl <= NOP_CONTROL;
        if (r_state == BUSY && r_cnt != '0) r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  mdu_hilo_ctrl_hilo_regfile #(
    .WIDTH(WIDTH)
  ) u_hilo (
    .clk     (clk),
    .rst     (rst),
    .i_commit(w_commit),
    .i_result(bus.mdu_result),
    .i_hi_we (w_hi_we),
    .i_lo_we (w_lo_we),
    .i_wdata (bus.op_a),
    .o_hi    (bus.hi),
    .o_lo    (bus.lo)
  );

  assign bus.mdu_ctrl = r_mdu_ctrl;
  assign bus.mdu_a    = r_mdu_a;
  assign bus.mdu_b    = r_mdu_b;
  assign bus.stall    = w_stall;
  assign bus.busy     = (r_state == BUSY);

endmodule

// File: tb/tb_mdu_hilo_ctrl.sv
// Directed bench for mdu_hilo_ctrl with a behavioural MDU (combinational multiply, 33-cycle divide).
module tb_mdu_hilo_ctrl;
  import mdu_hilo_ctrl_pkg::*;

  logic clk;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  logic force_ready;
  int   div_cnt;

  mdu_hilo_ctrl_if #(.WIDTH(32)) bus ();

  mdu_hilo_ctrl #(
    .WIDTH      (32),
    .MUL_LATENCY(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural MDU: divide result becomes ready in the 33rd cycle after start.
  logic signed [31:0] sa, sb, sq, sr;
  logic signed [63:0] sa64, sb64, smul;
  logic        [63:0] umul;
  assign sa   = bus.mdu_a;
  assign sb   = bus.mdu_b;
  assign sa64 = sa;
  assign sb64 = sb;
  assign smul = sa64 * sb64;
  assign umul = {32'b0, bus.mdu_a} * {32'b0, bus.mdu_b};
  assign sq   = (sb == 0) ? 32'sd0 : sa / sb;
  assign sr   = (sb == 0) ? 32'sd0 : sa % sb;

  always_ff @(posedge clk) begin
    if (is_div(bus.mdu_ctrl)) div_cnt <= div_cnt + 1;
    else                      div_cnt <= 0;
  end

  always_comb begin
    bus.mdu_result = '0;
    bus.mdu_ready  = force_ready;
    case (bus.mdu_ctrl)
      MULT_CONTROL:  begin bus.mdu_result = smul; bus.mdu_ready = 1'b1; end
      MULTU_CONTROL: begin bus.mdu_result = umul; bus.mdu_ready = 1'b1; end
      DIV_CONTROL: begin
        bus.mdu_result = {sr, sq};
        if (div_cnt >= 32) bus.mdu_ready = 1'b1;
      end
      DIVU_CONTROL: begin
        if (bus.mdu_b != 0) bus.mdu_result = {bus.mdu_a % bus.mdu_b, bus.mdu_a / bus.mdu_b};
        if (div_cnt >= 32) bus.mdu_ready = 1'b1;
      end
      default: ;
    endcase
  end

  // Drives one op right after a rising edge; caller samples at the following negedge.
  task automatic drive_op(input logic [4:0] ctrl, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk);
    #1;
    bus.op_valid = 1'b1;
    bus.op_ctrl  = ctrl;
    bus.op_a     = a;
    bus.op_b     = b;
  endtask

  task automatic drop_op();
    bus.op_valid = 1'b0;
    bus.op_ctrl  = 5'd0;
    bus.op_a     = 32'hDEAD_BEEF;
    bus.op_b     = 32'h0BAD_F00D;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (bus.hi !== 32'h0)       begin errors++; $display("FAIL reset_hi got=%h exp=0", bus.hi); end
    checks++; if (bus.lo !== 32'h0)       begin errors++; $display("FAIL reset_lo got=%h exp=0", bus.lo); end
    checks++; if (bus.stall !== 1'b0)     begin errors++; $display("FAIL reset_stall got=%b exp=0", bus.stall); end
    checks++; if (bus.busy !== 1'b0)      begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.mdu_ctrl !== 5'd0)  begin errors++; $display("FAIL reset_mdu_ctrl got=%h exp=0", bus.mdu_ctrl); end
    checks++; if (bus.mdu_a !== 32'h0 || bus.mdu_b !== 32'h0)
      begin errors++; $display("FAIL reset_mdu_ops got=%h/%h exp=0/0", bus.mdu_a, bus.mdu_b); end
    #2 rst = 1'b1;
  endtask

  task automatic test_mult();
    drive_op(MULT_CONTROL, 32'hFFFF_FFFE, 32'd3);
    @(negedge clk);
    checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL mult_issue_stall got=%b exp=1", bus.stall); end
    checks++; if (bus.busy !== 1'b0)  begin errors++; $display("FAIL mult_issue_busy got=%b exp=0", bus.busy); end
    @(posedge clk);
    #1 drop_op();
    @(negedge clk);
    checks++; if (bus.busy !== 1'b1)  begin errors++; $display("FAIL mult_busy got=%b exp=1", bus.busy); end
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL mult_commit_stall got=%b exp=0", bus.stall); end
    checks++; if (bus.mdu_ctrl !== MULT_CONTROL || bus.mdu_a !== 32'hFFFF_FFFE || bus.mdu_b !== 32'd3)
      begin errors++; $display("FAIL mult_latch got=%h/%h/%h exp=01/fffffffe/00000003", bus.mdu_ctrl, bus.mdu_a, bus.mdu_b); end
    @(negedge clk);
    checks++; if (bus.hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult_hi got=%h exp=ffffffff", bus.hi); end
    checks++; if (bus.lo !== 32'hFFFF_FFFA) begin errors++; $display("FAIL mult_lo got=%h exp=fffffffa", bus.lo); end
    checks++; if (bus.busy !== 1'b0 || bus.mdu_ctrl !== 5'd0)
      begin errors++; $display("FAIL mult_idle got busy=%b ctrl=%h exp busy=0 ctrl=0", bus.busy, bus.mdu_ctrl); end
  endtask

  task automatic test_multu();
    drive_op(MULTU_CONTROL, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    @(posedge clk);
    #1 drop_op();
    @(negedge clk);
    @(negedge clk);
    checks++; if (bus.hi !== 32'hFFFF_FFFE) begin errors++; $display("FAIL multu_hi got=%h exp=fffffffe", bus.hi); end
    checks++; if (bus.lo !== 32'h0000_0001) begin errors++; $display("FAIL multu_lo got=%h exp=00000001", bus.lo); end
  endtask

  task automatic test_div();
    int n    = 0;
    bit seen = 1'b0;
    drive_op(DIV_CONTROL, 32'hFFFF_FFF9, 32'd2);
    @(posedge clk);
    #1 drop_op();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.stall) n++;
      else begin seen = 1'b1; break; end
    end
    checks++; if (!seen)   begin errors++; $display("FAIL div_timeout got=no_release exp=release"); end
    checks++; if (n != 32) begin errors++; $display("FAIL div_stall_cycles got=%0d exp=32", n); end
    checks++; if (bus.hi !== 32'hFFFF_FFFE) begin errors++; $display("FAIL div_no_bypass got=%h exp=fffffffe", bus.hi); end
    @(negedge clk);
    checks++; if (bus.hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_rem got=%h exp=ffffffff", bus.hi); end
    checks++; if (bus.lo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_quot got=%h exp=fffffffd", bus.lo); end
    checks++; if (bus.busy !== 1'b0)        begin errors++; $display("FAIL div_idle got=%b exp=0", bus.busy); end
  endtask

  task automatic test_flush();
    drive_op(DIVU_CONTROL, 32'd100, 32'd7);
    @(posedge clk);
    #1 drop_op();
    repeat (4) @(posedge clk);
    #1 bus.flush = 1'b1;
    @(negedge clk);
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL flush_stall got=%b exp=0", bus.stall); end
    @(posedge clk);
    #1 bus.flush = 1'b0;
    @(negedge clk);
    checks++; if (bus.mdu_ctrl !== 5'd0 || bus.busy !== 1'b0)
      begin errors++; $display("FAIL flush_idle got ctrl=%h busy=%b exp ctrl=0 busy=0", bus.mdu_ctrl, bus.busy); end
    checks++; if (bus.hi !== 32'hFFFF_FFFF || bus.lo !== 32'hFFFF_FFFD)
      begin errors++; $display("FAIL flush_hilo got=%h/%h exp=ffffffff/fffffffd", bus.hi, bus.lo); end
    drive_op(DIVU_CONTROL, 32'd100, 32'd7);
    @(posedge clk);
    #1 drop_op();
    repeat (2) @(posedge clk);
    #1 begin bus.flush = 1'b1; force_ready = 1'b1; end
    @(negedge clk);
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL flush_ready_stall got=%b exp=0", bus.stall); end
    @(posedge clk);
    #1 begin bus.flush = 1'b0; force_ready = 1'b0; end
    @(negedge clk);
    checks++; if (bus.hi !== 32'hFFFF_FFFF || bus.lo !== 32'hFFFF_FFFD || bus.busy !== 1'b0)
      begin errors++; $display("FAIL flush_ready_nocommit got=%h/%h busy=%b exp=ffffffff/fffffffd busy=0", bus.hi, bus.lo, bus.busy); end
  endtask

  task automatic test_back_to_back();
    drive_op(MTHI_CONTROL, 32'h1234_5678, 32'h0);
    @(negedge clk);
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL mthi_stall got=%b exp=0", bus.stall); end
    @(posedge clk);
    #1 begin bus.op_ctrl = MTLO_CONTROL; bus.op_a = 32'h9ABC_DEF0; end
    @(negedge clk);
    checks++; if (bus.hi !== 32'h1234_5678 || bus.lo !== 32'hFFFF_FFFD)
      begin errors++; $display("FAIL mthi_write got=%h/%h exp=12345678/fffffffd", bus.hi, bus.lo); end
    checks++; if (bus.stall !== 1'b0 || bus.busy !== 1'b0)
      begin errors++; $display("FAIL mtlo_stall got stall=%b busy=%b exp=0/0", bus.stall, bus.busy); end
    @(posedge clk);
    #1 begin bus.op_ctrl = MTHI_CONTROL; bus.op_a = 32'h5555_AAAA; bus.flush = 1'b1; end
    @(negedge clk);
    checks++; if (bus.lo !== 32'h9ABC_DEF0) begin errors++; $display("FAIL mtlo_write got=%h exp=9abcdef0", bus.lo); end
    @(posedge clk);
    #1 begin bus.flush = 1'b0; bus.op_ctrl = 5'd31; end
    @(negedge clk);
    checks++; if (bus.hi !== 32'h1234_5678) begin errors++; $display("FAIL idle_flush_mthi got=%h exp=12345678", bus.hi); end
    checks++; if (bus.stall !== 1'b0)       begin errors++; $display("FAIL unknown_stall got=%b exp=0", bus.stall); end
    @(posedge clk);
    #1 drop_op();
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0 || bus.hi !== 32'h1234_5678 || bus.lo !== 32'h9ABC_DEF0)
      begin errors++; $display("FAIL unknown_noop got busy=%b hilo=%h/%h exp 0 12345678/9abcdef0", bus.busy, bus.hi, bus.lo); end
  endtask

  task automatic test_async_reset();
    drive_op(DIV_CONTROL, 32'd1000, 32'd3);
    @(posedge clk);
    #1 drop_op();
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.busy !== 1'b1 || bus.stall !== 1'b1)
      begin errors++; $display("FAIL arst_pre got busy=%b stall=%b exp=1/1", bus.busy, bus.stall); end
    #1 rst = 1'b0;
    #1;
    checks++; if (bus.busy !== 1'b0 || bus.stall !== 1'b0)
      begin errors++; $display("FAIL arst_state got busy=%b stall=%b exp=0/0", bus.busy, bus.stall); end
    checks++; if (bus.hi !== 32'h0 || bus.lo !== 32'h0)
      begin errors++; $display("FAIL arst_hilo got=%h/%h exp=0/0", bus.hi, bus.lo); end
    checks++; if (bus.mdu_ctrl !== 5'd0) begin errors++; $display("FAIL arst_ctrl got=%h exp=0", bus.mdu_ctrl); end
    @(negedge clk);
    #1 rst = 1'b1;
  endtask

  initial begin
    rst         = 1'b0;
    force_ready = 1'b0;
    bus.flush   = 1'b0;
    drop_op();
    test_reset();
    test_mult();
    test_multu();
    test_div();
    test_flush();
    test_back_to_back();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
